// File: rtl/chan_mux_scan_if.sv
// Channel mux bus: flattened channel data and controls in, selected data and status out.
interface chan_mux_scan_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned NCH   = 3
);
    localparam int unsigned SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] din;
    logic [SELW-1:0]      sel;
    logic                 mode;
    logic                 hold;
    logic [WIDTH-1:0]     dout;
    logic [SELW-1:0]      ch;
    logic                 sel_err;
    logic                 scan_wrap;

    modport master (
        output din, sel, mode, hold,
        input  dout, ch, sel_err, scan_wrap
    );

    modport slave (
        input  din, sel, mode, hold,
        output dout, ch, sel_err, scan_wrap
    );
endinterface

// File: rtl/chan_mux_scan.sv
// Registered N-channel mux with hold, out-of-range select flag and an auto-scan
// mode that dwells DWELL cycles on each channel.
module chan_mux_scan #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned NCH   = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    chan_mux_scan_if.slave bus
);
    localparam int unsigned SELW = $clog2(NCH);
    localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [WIDTH-1:0] chan [NCH];

    logic [SELW-1:0]  ch_q,   ch_next;
    logic [CNTW-1:0]  cnt_q,  cnt_next;
    logic [WIDTH-1:0] dout_q, dout_next;
    logic             err_q,  err_next;
    logic             wrap_q, wrap_next;
    logic             mode_q, mode_next;
    logic             sel_ok;

    // Unflatten the channel bus so the select can index it directly.
    always_comb begin
        for (int k = 0; k < int'(NCH); k++) begin
            chan[k] = bus.din[k*WIDTH +: WIDTH];
        end
    end

    assign sel_ok = 32'(bus.sel) < NCH;

    // Next-state: hold freezes everything; a mode change restarts the dwell count.
    always_comb begin
        ch_next   = ch_q;
        cnt_next  = cnt_q;
        err_next  = err_q;
        wrap_next = 1'b0;
        mode_next = mode_q;
        dout_next = dout_q;
        if (!bus.hold) begin
            mode_next = bus.mode;
            if (!bus.mode) begin
                cnt_next = '0;
                if (sel_ok) begin
                    ch_next  = bus.sel;
                    err_next = 1'b0;
                end else begin
                    err_next = 1'b1;
                end
            end else begin
                err_next = 1'b0;
                if (bus.mode != mode_q) begin
                    cnt_next = '0;
                end else if (cnt_q == CNTW'(DWELL - 1)) begin
                    cnt_next = '0;
                    if (ch_q == SELW'(NCH - 1)) begin
                        ch_next   = '0;
                        wrap_next = 1'b1;
                    end else begin
                        ch_next = ch_q + SELW'(1);
                    end
                end else begin
                    cnt_next = cnt_q + CNTW'(1);
                end
            end
            dout_next = chan[ch_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            ch_q   <= ch_next;
            cnt_q  <= cnt_next;
            dout_q <= dout_next;
            err_q  <= err_next;
            wrap_q <= wrap_next;
            mode_q <= mode_next;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.ch        = ch_q;
    assign bus.sel_err   = err_q;
    assign bus.scan_wrap = wrap_q;
endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench for chan_mux_scan (WIDTH=2, NCH=3, DWELL=4) with hand-computed expectations.
module tb_chan_mux_scan;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [5:0] base_din;

    chan_mux_scan_if #(.WIDTH(2), .NCH(3)) bus ();

    chan_mux_scan #(.WIDTH(2), .NCH(3), .DWELL(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel value from the base pattern {11,10,01}.
    function automatic int chval(input int k);
        logic [5:0] d;
        d = base_din;
        return int'(d[k*2 +: 2]);
    endfunction

    initial begin
        total    = 0;
        bad      = 0;
        base_din = 6'b111001;
        rst_n    = 1'b0;
        bus.din  = base_din;
        bus.sel  = 2'd0;
        bus.mode = 1'b0;
        bus.hold = 1'b0;

        #3;
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_ch",   32'(bus.ch), 0);
        check("rst_err",  32'(bus.sel_err), 0);
        check("rst_wrap", 32'(bus.scan_wrap), 0);
        #9 rst_n = 1'b1;

        // Manual select over all three channels.
        for (int s = 0; s < 3; s++) begin
            bus.sel = 2'(s);
            step();
            check("man_ch",   32'(bus.ch), s);
            check("man_dout", 32'(bus.dout), chval(s));
            check("man_err",  32'(bus.sel_err), 0);
        end

        // Out-of-range select keeps ch and still tracks that channel's data.
        bus.sel = 2'd1;
        step();
        bus.sel = 2'd3;
        step();
        check("oor_ch",   32'(bus.ch), 1);
        check("oor_dout", 32'(bus.dout), 2);
        check("oor_err",  32'(bus.sel_err), 1);
        bus.din = 6'b110101;
        step();
        check("oor_track", 32'(bus.dout), 1);
        check("oor_err2",  32'(bus.sel_err), 1);
        bus.din = base_din;
        bus.sel = 2'd0;
        step();
        check("oor_clr_ch",  32'(bus.ch), 0);
        check("oor_clr_err", 32'(bus.sel_err), 0);

        // Scan from ch=0: dwell 4 per channel, wrap pulse every 12 edges.
        bus.mode = 1'b1;
        for (int i = 0; i < 27; i++) begin
            step();
            check("scan_ch",   32'(bus.ch), (i / 4) % 3);
            check("scan_dout", 32'(bus.dout), chval((i / 4) % 3));
            check("scan_wrap", 32'(bus.scan_wrap), (i > 0 && i % 12 == 0) ? 1 : 0);
        end

        // Now at ch=0, cnt=2: freeze for 5 edges while din churns.
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din = 6'(i * 13 + 7);
            step();
            check("hold_ch",   32'(bus.ch), 0);
            check("hold_dout", 32'(bus.dout), 1);
            check("hold_wrap", 32'(bus.scan_wrap), 0);
        end
        bus.din  = base_din;
        bus.hold = 1'b0;
        step();
        check("rel_ch0", 32'(bus.ch), 0);
        step();
        check("rel_ch1",   32'(bus.ch), 1);
        check("rel_dout1", 32'(bus.dout), 2);

        // Manual to scan at ch=2; sel is ignored while scanning.
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        step();
        check("m2s_pre_ch", 32'(bus.ch), 2);
        bus.mode = 1'b1;
        bus.sel  = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            check("m2s_ch",   32'(bus.ch), 2);
            check("m2s_err",  32'(bus.sel_err), 0);
            check("m2s_wrap", 32'(bus.scan_wrap), 0);
        end
        step();
        check("m2s_wrap_ch", 32'(bus.ch), 0);
        check("m2s_wrap",    32'(bus.scan_wrap), 1);
        step();
        check("m2s_wrap_end", 32'(bus.scan_wrap), 0);

        // Scan to manual follows sel on the same edge.
        bus.mode = 1'b0;
        bus.sel  = 2'd1;
        step();
        check("s2m_ch",   32'(bus.ch), 1);
        check("s2m_dout", 32'(bus.dout), 2);

        // Reset mid-scan clears outputs without a clock edge.
        bus.mode = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", 32'(bus.dout), 0);
        check("arst_ch",   32'(bus.ch), 0);
        check("arst_err",  32'(bus.sel_err), 0);
        step();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_ch", 32'(bus.ch), 0);
        end
        step();
        check("post_rst_adv", 32'(bus.ch), 1);
        check("post_rst_dout", 32'(bus.dout), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
